// File: rtl/flush_array.sv
// flush_array: small set-indexed storage array with per-byte write masks,
// two combinational read ports with write-to-read forwarding, and an
// optional flush sweep that invalidates every set one per cycle.
// Optional feature macro: FLUSH_ARRAY_FLUSH_EN (flush FSM, sweep counter, busy).
// With the macro undefined, flush is ignored and busy is tied low.

// One read port: returns stored entry, merged with a same-cycle write when
// the write targets the same set, and blanks everything while busy.
module flush_array_rport #(
  parameter int s_index = 3,
  parameter int width   = 32
) (
  input  logic                                 read,
  input  logic [s_index-1:0]                   rindex,
  input  logic [(2**s_index)-1:0][width-1:0]   mem_data,
  input  logic [(2**s_index)-1:0]              mem_valid,
  input  logic                                 load,
  input  logic [s_index-1:0]                   windex,
  input  logic [(width/8)-1:0]                 wmask,
  input  logic [width-1:0]                     datain,
  input  logic                                 busy,
  output logic [width-1:0]                     dataout,
  output logic                                 valid
);
  localparam int s_mask = width / 8;

  logic hit;
  assign hit = load & (rindex == windex) & (|wmask);

  // Read mux with byte-wise forwarding of the in-flight write.
  always_comb begin
    dataout = '0;
    valid   = 1'b0;
    if (read && !busy) begin
      dataout = mem_data[rindex];
      valid   = mem_valid[rindex];
      if (hit) begin
        for (int b = 0; b < s_mask; b++)
          if (wmask[b]) dataout[8*b +: 8] = datain[8*b +: 8];
        valid = 1'b1;
      end
    end
  end
endmodule

module flush_array #(
  parameter int s_index = 3,
  parameter int width   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read0,
  input  logic [s_index-1:0]      rindex0,
  output logic [width-1:0]        dataout0,
  output logic                    valid0,
  input  logic                    read1,
  input  logic [s_index-1:0]      rindex1,
  output logic [width-1:0]        dataout1,
  output logic                    valid1,
  input  logic                    load,
  input  logic [s_index-1:0]      windex,
  input  logic [(width/8)-1:0]    wmask,
  input  logic [width-1:0]        datain,
  input  logic                    flush,
  output logic                    busy
);
  localparam int sets   = 2**s_index;
  localparam int s_mask = width / 8;
  localparam int NUM_RP = 2;

  typedef struct packed {
    logic                en;
    logic [s_index-1:0]  idx;
    logic [s_mask-1:0]   mask;
    logic [width-1:0]    data;
  } wreq_t;

  logic [sets-1:0][width-1:0] mem_data;
  logic [sets-1:0]            mem_valid;

  logic                sweep_clr;
  logic [s_index-1:0]  sweep_idx;
  logic                flush_take;
  wreq_t               wreq;

`ifdef FLUSH_ARRAY_FLUSH_EN
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;
  localparam logic [s_index-1:0] LAST = s_index'(sets - 1);

  state_t             state, state_nxt;
  logic [s_index-1:0] cnt, cnt_nxt;

  // Sweep state and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: start on flush from IDLE, walk every set once, then return.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (flush) begin
        state_nxt = SWEEP;
        cnt_nxt   = '0;
      end
      SWEEP: if (cnt == LAST) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + s_index'(1);
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy       = (state == SWEEP);
  assign flush_take = (state == IDLE) & flush;
  assign sweep_clr  = busy;
  assign sweep_idx  = cnt;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign busy       = 1'b0;
  assign flush_take = 1'b0;
  assign sweep_clr  = 1'b0;
  assign sweep_idx  = '0;
`endif

  // A flush accepted this cycle wins over a concurrent write.
  assign wreq = '{en: load & ~busy & ~flush_take, idx: windex, mask: wmask, data: datain};

  // Storage: byte-masked writes and sweep invalidation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_data  <= '0;
      mem_valid <= '0;
    end else begin
      if (wreq.en) begin
        for (int b = 0; b < s_mask; b++)
          if (wreq.mask[b]) mem_data[wreq.idx][8*b +: 8] <= wreq.data[8*b +: 8];
        if (|wreq.mask) mem_valid[wreq.idx] <= 1'b1;
      end
      if (sweep_clr) mem_valid[sweep_idx] <= 1'b0;
    end
  end

  logic [NUM_RP-1:0]                rp_read;
  logic [NUM_RP-1:0][s_index-1:0]   rp_idx;
  logic [NUM_RP-1:0][width-1:0]     rp_data;
  logic [NUM_RP-1:0]                rp_valid;

  assign rp_read = {read1, read0};
  assign rp_idx  = {rindex1, rindex0};
  assign dataout0 = rp_data[0];
  assign dataout1 = rp_data[1];
  assign valid0   = rp_valid[0];
  assign valid1   = rp_valid[1];

  for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
    flush_array_rport #(.s_index(s_index), .width(width)) u_rp (
      .read      (rp_read[p]),
      .rindex    (rp_idx[p]),
      .mem_data  (mem_data),
      .mem_valid (mem_valid),
      .load      (load),
      .windex    (windex),
      .wmask     (wmask),
      .datain    (datain),
      .busy      (busy),
      .dataout   (rp_data[p]),
      .valid     (rp_valid[p])
    );
  end
endmodule

// File: tb/tb_flush_array.sv
// Directed bench for flush_array at default parameters (8 sets x 32 bits).
module tb_flush_array;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read0 = 1'b0, read1 = 1'b0;
  logic [2:0]  rindex0 = '0, rindex1 = '0;
  logic [31:0] dataout0, dataout1;
  logic        valid0, valid1;
  logic        load = 1'b0;
  logic [2:0]  windex = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] datain = '0;
  logic        flush = 1'b0;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  flush_array dut (
    .clk(clk), .rst(rst),
    .read0(read0), .rindex0(rindex0), .dataout0(dataout0), .valid0(valid0),
    .read1(read1), .rindex1(rindex1), .dataout1(dataout1), .valid1(valid1),
    .load(load), .windex(windex), .wmask(wmask), .datain(datain),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are changed 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] m);
    load = 1'b1; windex = idx; datain = d; wmask = m;
    tick();
    load = 1'b0; wmask = '0;
  endtask

  task automatic rd0(input logic [2:0] idx);
    read0 = 1'b1; rindex0 = idx;
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("sweep_end", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    rd0(3'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_data", dataout0, 32'h0);
    chk("rst_valid", {31'b0, valid0}, 32'd0);
    @(negedge clk); rst = 1'b1;
    #1;

    // Basic write / read on both ports
    wr(3'd3, 32'hDEADBEEF, 4'hF);
    rd0(3'd3); read1 = 1'b1; rindex1 = 3'd2; #1;
    chk("rd0_set3", dataout0, 32'hDEADBEEF);
    chk("rd0_set3_v", {31'b0, valid0}, 32'd1);
    chk("rd1_set2", dataout1, 32'h0);
    chk("rd1_set2_v", {31'b0, valid1}, 32'd0);
    read0 = 1'b0; #1;
    chk("rd0_off", dataout0, 32'h0);
    chk("rd0_off_v", {31'b0, valid0}, 32'd0);

    // Masked write with same-cycle forwarding
    wr(3'd5, 32'h11223344, 4'hF);
    load = 1'b1; windex = 3'd5; datain = 32'hAABBCCDD; wmask = 4'b0101;
    rd0(3'd5); rindex1 = 3'd5; #1;
    chk("fwd_data", dataout0, 32'h11BB33DD);
    chk("fwd_valid", {31'b0, valid0}, 32'd1);
    chk("fwd_rd1", dataout1, 32'h11BB33DD);
    tick(); load = 1'b0; wmask = '0; #1;
    chk("merge_stored", dataout0, 32'h11BB33DD);
    read1 = 1'b0;

    // Zero mask: no forwarding, no data or valid change
    load = 1'b1; windex = 3'd6; datain = 32'hFFFFFFFF; wmask = 4'h0;
    rd0(3'd6);
    chk("m0_fwd_data", dataout0, 32'h0);
    chk("m0_fwd_valid", {31'b0, valid0}, 32'd0);
    tick(); load = 1'b0; #1;
    chk("m0_data", dataout0, 32'h0);
    chk("m0_valid", {31'b0, valid0}, 32'd0);
    wr(3'd3, 32'h0, 4'h0);
    rd0(3'd3);
    chk("m0_keep", dataout0, 32'hDEADBEEF);

    // Fill every set
    for (int i = 0; i < 8; i++) wr(3'(i), 32'hA0A0A000 | i, 4'hF);
    for (int i = 0; i < 8; i++) begin
      rd0(3'(i));
      chk("fill_v", {31'b0, valid0}, 32'd1);
    end

`ifdef FLUSH_ARRAY_FLUSH_EN
    // Flush sweep: busy for 8 cycles, loads and flushes ignored, reads blank
    flush = 1'b1; tick(); flush = 1'b0;
    rd0(3'd0);
    for (int k = 0; k < 8; k++) begin
      chk("sweep_busy", {31'b0, busy}, 32'd1);
      chk("sweep_rd", dataout0, 32'h0);
      chk("sweep_rv", {31'b0, valid0}, 32'd0);
      if (k == 2) begin load = 1'b1; windex = 3'd0; datain = 32'hFFFFFFFF; wmask = 4'hF; end
      if (k == 3) begin load = 1'b0; wmask = '0; flush = 1'b1; end
      if (k == 4) flush = 1'b0;
      tick();
    end
    chk("sweep_done", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd0(3'(i));
      chk("post_v", {31'b0, valid0}, 32'd0);
      chk("post_data", dataout0, 32'hA0A0A000 | i);
    end
    wr(3'd7, 32'h77777777, 4'hF);
    rd0(3'd7);
    chk("rewrite", dataout0, 32'h77777777);
    chk("rewrite_v", {31'b0, valid0}, 32'd1);

    // Flush and load in the same cycle: write dropped
    flush = 1'b1; load = 1'b1; windex = 3'd1; datain = 32'h12345678; wmask = 4'hF;
    tick();
    flush = 1'b0; load = 1'b0; wmask = '0; #1;
    chk("fl_ld_busy", {31'b0, busy}, 32'd1);
    wait_idle();
    rd0(3'd1);
    chk("fl_ld_data", dataout0, 32'hA0A0A001);
    chk("fl_ld_v", {31'b0, valid0}, 32'd0);

    // Reset in the middle of a sweep
    wr(3'd2, 32'h22222222, 4'hF);
    flush = 1'b1; tick(); flush = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b0; #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b1;
    rd0(3'd2);
    chk("mid_rst_v", {31'b0, valid0}, 32'd0);
    chk("mid_rst_data", dataout0, 32'h0);
    wr(3'd4, 32'h44444444, 4'hF);
    rd0(3'd4);
    chk("first_wr", dataout0, 32'h44444444);
    chk("first_wr_v", {31'b0, valid0}, 32'd1);
    chk("first_busy", {31'b0, busy}, 32'd0);
`else
    // Flush has no effect in this build
    flush = 1'b1; tick(); flush = 1'b0; #1;
    chk("nofl_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd0(3'(i));
      chk("nofl_v", {31'b0, valid0}, 32'd1);
      chk("nofl_data", dataout0, 32'hA0A0A000 | i);
    end
    // Asynchronous reset without a clock edge
    #2 rst = 1'b0; #1;
    rd0(3'd3);
    chk("arst_v", {31'b0, valid0}, 32'd0);
    chk("arst_data", dataout0, 32'h0);
    @(negedge clk); rst = 1'b1;
    wr(3'd4, 32'h44444444, 4'hF);
    rd0(3'd4);
    chk("first_wr", dataout0, 32'h44444444);
    chk("first_wr_v", {31'b0, valid0}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/flush_array.md
FLUSH_ARRAY -- requirements
Module: flush_array

Interface
REQ-001 Parameter s_index, default 3, sets = 2**s_index.
REQ-002 Parameter width, default 32, entry width in bits, SHALL be a multiple of 8; s_mask = width/8.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 read0  input  1  port-0 read enable.
REQ-006 rindex0  input  s_index  port-0 read set.
REQ-007 dataout0  output  width  port-0 read data.
REQ-008 valid0  output  1  port-0 entry valid.
REQ-009 read1, rindex1, dataout1, valid1: second read port, identical to port 0.
REQ-010 load  input  1  write enable.
REQ-011 windex  input  s_index  write set.
REQ-012 wmask  input  s_mask  byte write enables, bit i covers datain[8i+7:8i].
REQ-013 datain  input  width  write data.
REQ-014 flush  input  1  single-cycle request to invalidate all sets.
REQ-015 busy  output  1  flush sweep in progress.

Function
REQ-016 Storage: per set one width-bit data word plus one valid bit.
REQ-017 Reads combinational, zero latency; both ports independent, same or different sets.
REQ-018 readN=0 -> dataoutN=0, validN=0.
REQ-019 readN=1, busy=0, no forwarding hit -> dataoutN=stored data, validN=stored valid.
REQ-020 Forwarding hit (readN & load & busy=0 & rindexN==windex & wmask!=0): bytes with wmask set from datain, others from stored data; validN=1.
REQ-021 readN=1 while busy=1 -> dataoutN=0, validN=0.
REQ-022 Write at rising edge when load=1, busy=0, flush=0: masked bytes of set windex updated, unmasked bytes kept; valid set to 1 iff wmask!=0.
REQ-023 load with wmask=0 SHALL change neither data nor valid.
REQ-024 FSM states IDLE, SWEEP; busy=1 exactly in SWEEP.
REQ-025 IDLE & flush=1 at edge T -> SWEEP, sweep counter=0; load in cycle T dropped (flush has priority).
REQ-026 Each SWEEP cycle clears valid[counter], data untouched; counter increments.
REQ-027 Clear of set sets-1 -> IDLE, counter=0; busy high exactly `sets` cycles (8 at defaults).
REQ-028 flush during SWEEP ignored; load during SWEEP ignored, no data/valid change.
REQ-029 Counter s_index bits, no wrap beyond sets-1.

Reset
REQ-030 rst low: all data 0, all valid 0, state IDLE, counter 0, busy 0, asynchronously, independent of clk.
REQ-031 rst asserted mid-SWEEP aborts sweep; after release block is IDLE with all entries invalid.
REQ-032 First write accepted on first rising edge with rst high.

Configuration
REQ-033 Macro FLUSH_ARRAY_FLUSH_EN defined: flush FSM, counter, busy behave per REQ-024..029.
REQ-034 Macro undefined: no FSM or counter; flush ignored; busy constant 0; all other behaviour unchanged.

Verification
REQ-035 Reset, write set 3 datain=32'hDEADBEEF wmask=4'hF, next cycle read0 set 3 -> dataout0=32'hDEADBEEF, valid0=1; read1 set 2 -> 0/valid1=0.
REQ-036 Set 5 holds 32'h11223344; write 32'hAABBCCDD wmask=4'b0101 while read0 set 5 -> same cycle dataout0=32'h11BB33DD, after edge stored 32'h11BB33DD.
REQ-037 Valid sets 0..7, pulse flush -> busy=1 for 8 cycles, load issued during busy dropped, reads return 0/0, afterwards all valid=0, data preserved (masked write of 0 bytes... verified by wmask=4'hF rewrite read-back).
REQ-038 flush and load to set 1 same cycle -> write dropped, sweep starts; set 1 valid=0 after sweep.
REQ-039 Assert rst at sweep cycle 4 -> busy=0 immediately, all valid=0 after release; new write accepted first edge.
REQ-040 Build without FLUSH_ARRAY_FLUSH_EN, pulse flush -> busy stays 0, valid bits unchanged.
